// File: rtl/pacote_ula.sv
// Shared definitions for the arbitrated logic unit: opcodes, FSM encoding and
// default data width.
package pacote_ula;

    localparam int LARGURA_PADRAO = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        ESPERA  = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_logica.sv
// Combinational bitwise logic unit shared by both requesters.
module unidade_logica
    import pacote_ula::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [1:0]         op,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] resultado
);

    always_comb begin
        resultado = '0;
        case (op)
            OP_AND:  resultado = a & b;
            OP_OR:   resultado = a | b;
            OP_XOR:  resultado = a ^ b;
            OP_NOT:  resultado = ~a;
            default: resultado = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_ula.sv
// Two-requester round-robin arbiter in front of one shared logic unit; the
// result is held with Valido until the consumer acknowledges it.
module arbitro_ula
    import pacote_ula::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Req0,
    input  logic [1:0]         Op0,
    input  logic [LARGURA-1:0] A0,
    input  logic [LARGURA-1:0] B0,
    input  logic               Req1,
    input  logic [1:0]         Op1,
    input  logic [LARGURA-1:0] A1,
    input  logic [LARGURA-1:0] B1,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic [LARGURA-1:0] Resultado,
    output logic               Zero,
    output logic               Dono,
    output logic               Valido,
    input  logic               Ack
);

    estado_t            estado, proximo;
    logic               ultimo;
    logic               sel_q;
    logic [1:0]         op_q;
    logic [LARGURA-1:0] a_q, b_q;
    logic [LARGURA-1:0] res_ul;

    unidade_logica #(.LARGURA(LARGURA)) u_ul (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .resultado (res_ul)
    );

    // On a tie the requester that was not granted last wins.
    always_comb begin
        proximo = estado;
        Gnt0    = 1'b0;
        Gnt1    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (Req0 && (!Req1 || ultimo)) Gnt0 = 1'b1;
                else if (Req1)                 Gnt1 = 1'b1;
                if (Req0 || Req1) proximo = EXECUTA;
            end
            EXECUTA: proximo = ESPERA;
            ESPERA:  if (Ack) proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado    <= OCIOSO;
            ultimo    <= 1'b1;
            sel_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            Resultado <= '0;
            Zero      <= 1'b0;
            Dono      <= 1'b0;
            Valido    <= 1'b0;
        end else begin
            estado <= proximo;
            if (Gnt0 || Gnt1) begin
                op_q   <= Gnt1 ? Op1 : Op0;
                a_q    <= Gnt1 ? A1  : A0;
                b_q    <= Gnt1 ? B1  : B0;
                sel_q  <= Gnt1;
                ultimo <= Gnt1;
            end
            if (estado == EXECUTA) begin
                Resultado <= res_ul;
                Zero      <= (res_ul == '0);
                Dono      <= sel_q;
                Valido    <= 1'b1;
            end
            // Resultado is left as-is after the handshake; Zero must drop with Valido.
            if (estado == ESPERA && Ack) begin
                Valido <= 1'b0;
                Zero   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_ula.sv
// Scoreboard bench for arbitro_ula: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_arbitro_ula;

    logic       Clock = 1'b0;
    logic       Resetn, Req0, Req1, Ack;
    logic [1:0] Op0, Op1;
    logic [7:0] A0, B0, A1, B1;
    logic       Gnt0, Gnt1, Zero, Dono, Valido;
    logic [7:0] Resultado;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       dono;
        logic [7:0] res;
    } esperado_t;

    esperado_t fila[$];

    arbitro_ula #(.LARGURA(8)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .Req0(Req0), .Op0(Op0), .A0(A0), .B0(B0),
        .Req1(Req1), .Op1(Op1), .A1(A1), .B1(B1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Resultado(Resultado), .Zero(Zero),
        .Dono(Dono), .Valido(Valido), .Ack(Ack)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Reference model: the unit is either free, or busy with one accepted
    // operation (one compute cycle, then waiting for the consumer's Ack).
    logic m_livre   = 1'b1;
    logic m_calcula = 1'b0;
    logic m_ultimo  = 1'b1;
    logic e0, e1;

    always @(negedge Clock) begin
        if (!Resetn) begin
            m_livre   = 1'b1;
            m_calcula = 1'b0;
            m_ultimo  = 1'b1;
            fila.delete();
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_livre) begin
                if (Req0 && Req1) begin
                    e0 = m_ultimo;
                    e1 = !m_ultimo;
                end else begin
                    e0 = Req0;
                    e1 = Req1;
                end
            end
            chk("gnt0", 32'(Gnt0), 32'(e0));
            chk("gnt1", 32'(Gnt1), 32'(e1));
            if (e0 || e1) begin
                fila.push_back('{e1, e1 ? ref_op(Op1, A1, B1) : ref_op(Op0, A0, B0)});
                m_ultimo  = e1;
                m_livre   = 1'b0;
                m_calcula = 1'b1;
            end else if (m_calcula) begin
                m_calcula = 1'b0;
            end else if (!m_livre && Ack) begin
                m_livre = 1'b1;
            end
        end
    end

    // Monitor: pops one expectation per Valido window and checks it holds.
    logic      v_ant = 1'b0;
    esperado_t atual = '{1'b0, 8'h00};

    always @(negedge Clock) begin
        if (!Resetn) begin
            v_ant = 1'b0;
        end else if (Valido) begin
            if (!v_ant) begin
                if (fila.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resultado_sem_pedido: got Valido=1 want no result at %0t", $time);
                end else begin
                    atual = fila.pop_front();
                end
            end
            chk("resultado", 32'(Resultado), 32'(atual.res));
            chk("dono",      32'(Dono),      32'(atual.dono));
            chk("zero",      32'(Zero),      32'(atual.res == 8'h00));
            v_ant = 1'b1;
        end else begin
            chk("zero_sem_valido", 32'(Zero), 32'd0);
            v_ant = 1'b0;
        end
    end

    task automatic single(input logic idx, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er);
        Ack = 1'b1;
        if (idx) begin Req1 = 1'b1; Op1 = op; A1 = a; B1 = b; end
        else     begin Req0 = 1'b1; Op0 = op; A0 = a; B0 = b; end
        #1;
        chk("single_gnt", 32'(idx ? Gnt1 : Gnt0), 32'd1);
        step();
        Req0 = 1'b0;
        Req1 = 1'b0;
        chk("single_valido_cedo", 32'(Valido), 32'd0);
        step();
        chk("single_valido", 32'(Valido),    32'd1);
        chk("single_res",    32'(Resultado), 32'(er));
        chk("single_dono",   32'(Dono),      32'(idx));
        chk("single_zero",   32'(Zero),      32'(er == 8'h00));
        step();
        chk("single_valido_fim", 32'(Valido), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0;
        Req0 = 1'b0; Req1 = 1'b0; Ack = 1'b0;
        Op0 = 2'b00; Op1 = 2'b00;
        A0 = 8'h00; B0 = 8'h00; A1 = 8'h00; B1 = 8'h00;
        step();
        step();
        chk("rst_valido",    32'(Valido),    32'd0);
        chk("rst_resultado", 32'(Resultado), 32'd0);
        chk("rst_zero",      32'(Zero),      32'd0);
        chk("rst_dono",      32'(Dono),      32'd0);
        chk("rst_gnt",       32'({Gnt1, Gnt0}), 32'd0);
        Resetn = 1'b1;
        step();

        // single AND request, then NOT (B must be ignored)
        single(1'b0, 2'b00, 8'hF0, 8'h3C, 8'h30);
        single(1'b0, 2'b11, 8'h0F, 8'hFF, 8'hF0);

        // back-pressure: XOR to zero, held for 5 cycles with both Req pending
        Ack = 1'b0;
        Req1 = 1'b1; Op1 = 2'b10; A1 = 8'h5A; B1 = 8'h5A;
        #1;
        chk("bp_gnt1", 32'(Gnt1), 32'd1);
        step();
        Req1 = 1'b0;
        step();
        Req0 = 1'b1;
        Req1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valido",    32'(Valido),    32'd1);
            chk("bp_resultado", 32'(Resultado), 32'd0);
            chk("bp_zero",      32'(Zero),      32'd1);
            chk("bp_dono",      32'(Dono),      32'd1);
            chk("bp_sem_gnt",   32'({Gnt1, Gnt0}), 32'd0);
            step();
        end
        Req0 = 1'b0; Req1 = 1'b0; Ack = 1'b1;
        step();

        // tie fairness: last grant went to 1, so 0 wins first
        Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("tie_gnt0", 32'(Gnt0), 32'(k % 6 == 0));
            chk("tie_gnt1", 32'(Gnt1), 32'(k % 6 == 3));
            Op0 = 2'($urandom_range(0, 3)); A0 = 8'($urandom); B0 = 8'($urandom);
            Op1 = 2'($urandom_range(0, 3)); A1 = 8'($urandom); B1 = 8'($urandom);
            step();
        end
        Req0 = 1'b0; Req1 = 1'b0;
        step();

        // stray Ack while idle
        for (int k = 0; k < 3; k++) begin
            chk("stray_valido", 32'(Valido), 32'd0);
            chk("stray_gnt",    32'({Gnt1, Gnt0}), 32'd0);
            step();
        end

        // reset while waiting for Ack
        Ack = 1'b0;
        Req0 = 1'b1; Op0 = 2'b01; A0 = 8'h12; B0 = 8'h34;
        step();
        Req0 = 1'b0;
        step();
        chk("rstm_valido_antes", 32'(Valido), 32'd1);
        #2 Resetn = 1'b0;
        #1;
        chk("rstm_valido",    32'(Valido),    32'd0);
        chk("rstm_resultado", 32'(Resultado), 32'd0);
        step();
        Resetn = 1'b1;
        Req0 = 1'b1; Req1 = 1'b1; Ack = 1'b1;
        #1;
        chk("rstm_gnt0", 32'(Gnt0), 32'd1);
        chk("rstm_gnt1", 32'(Gnt1), 32'd0);
        step();
        Req0 = 1'b0; Req1 = 1'b0;
        step();
        step();

        // random traffic, Ack often low and often outside the wait window
        for (int k = 0; k < 600; k++) begin
            Req0 = 1'($urandom_range(0, 1));
            Req1 = 1'($urandom_range(0, 1));
            Op0 = 2'($urandom_range(0, 3)); A0 = 8'($urandom); B0 = 8'($urandom);
            Op1 = 2'($urandom_range(0, 3)); A1 = 8'($urandom); B1 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) B1 = A1;
            Ack = ($urandom_range(0, 2) == 0);
            step();
        end
        Req0 = 1'b0; Req1 = 1'b0; Ack = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("fila_final", 32'(fila.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
